// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared state encodings, fault codes and widths for the shaft model.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int POS_W = 32;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_UP      = 3'd1,
        ST_DOWN    = 3'd2,
        ST_DOOR    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_BOTH       = 3'd1;
    localparam logic [2:0] FC_REVERSAL   = 3'd2;
    localparam logic [2:0] FC_OVERTRAVEL = 3'd3;
    localparam logic [2:0] FC_DOOR       = 3'd4;

    // Lowest code wins when several causes coincide in one cycle.
    function automatic logic [2:0] first_fault(input logic both, input logic reversal,
                                               input logic overtravel, input logic door_bad);
        if (both)            return FC_BOTH;
        else if (reversal)   return FC_REVERSAL;
        else if (overtravel) return FC_OVERTRAVEL;
        else if (door_bad)   return FC_DOOR;
        else                 return FC_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_shaft_model_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_shaft_model_if
// Purpose  : Motor/door/position link between controller (master) and shaft plant (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_shaft_model_if;
    import elevator_pkg::*;

    logic             motor_up;
    logic             motor_down;
    logic             door;
    logic [POS_W-1:0] position;
    logic             moving;
    logic             door_open;
    logic             at_floor;
    logic             fault;
    logic [2:0]       fault_code;

    modport master (
        output motor_up, motor_down, door,
        input  position, moving, door_open, at_floor, fault, fault_code
    );

    modport slave (
        input  motor_up, motor_down, door,
        output position, moving, door_open, at_floor, fault, fault_code
    );

endinterface
`default_nettype wire

// File: rtl/elevator_shaft_timer.sv
`default_nettype none
// ============================================================================
// Module   : elevator_shaft_timer
// Purpose  : Loadable saturating up-counter with a terminal-count flag at a run-time limit.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_shaft_timer #(
    parameter int MAX_COUNT = 7,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load,
    input  logic          enable,
    input  logic [CW-1:0] load_value,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          terminal
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != CW'(MAX_COUNT))) begin
            count <= count + CW'(1);
        end
    end

    assign terminal = enable && (count == limit);

endmodule
`default_nettype wire

// File: rtl/elevator_shaft_model.sv
`default_nettype none
// ============================================================================
// Module   : elevator_shaft_model
// Purpose  : Behavioural cabin/shaft plant: timed floor travel, door cycles, sticky faults.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_shaft_model
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT     = 10,
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_TICKS      = 4,
    parameter int START_FLOOR     = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    elevator_shaft_model_if.slave  bus
);

    localparam int CNT_MAX = ((TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS) - 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [POS_W-1:0] TOP_FLOOR  = POS_W'(FLOOR_COUNT - 1);
    localparam logic [POS_W-1:0] HOME_FLOOR = POS_W'(START_FLOOR);
    localparam logic [CW-1:0]    TRAVEL_END = CW'(TICKS_PER_FLOOR - 1);
    localparam logic [CW-1:0]    ARRIVE_AT  = CW'(TICKS_PER_FLOOR - 2);
    localparam logic [CW-1:0]    DOOR_END   = CW'(DOOR_TICKS - 1);

    state_t        state;
    logic          active;
    logic          terminal;
    logic [CW-1:0] count;
    logic [CW-1:0] limit;
    logic [2:0]    code_next;
    logic          both;
    logic          at_top;
    logic          at_bottom;

    assign active    = (state == ST_UP) || (state == ST_DOWN) || (state == ST_DOOR);
    assign limit     = (state == ST_DOOR) ? DOOR_END : TRAVEL_END;
    assign both      = bus.motor_up & bus.motor_down;
    assign at_top    = (bus.position == TOP_FLOOR);
    assign at_bottom = (bus.position == '0);

    // Counter sits at zero whenever idle, so entering any timed state starts from zero.
    elevator_shaft_timer #(
        .MAX_COUNT (CNT_MAX),
        .CW        (CW)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (!active || terminal),
        .enable     (active),
        .load_value ('0),
        .limit      (limit),
        .count      (count),
        .terminal   (terminal)
    );

    always_comb begin
        code_next = FC_NONE;
        case (state)
            ST_STOPPED: code_next = first_fault(both, 1'b0,
                                    (bus.motor_up && at_top) || (bus.motor_down && at_bottom), 1'b0);
            ST_UP:      code_next = first_fault(both, bus.motor_down,
                                    terminal && bus.motor_up && at_top, bus.door);
            ST_DOWN:    code_next = first_fault(both, bus.motor_up,
                                    terminal && bus.motor_down && at_bottom, bus.door);
            ST_DOOR:    code_next = first_fault(both, 1'b0, 1'b0, bus.motor_up | bus.motor_down);
            default:    code_next = FC_NONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_STOPPED;
            bus.position   <= HOME_FLOOR;
            bus.moving     <= 1'b0;
            bus.door_open  <= 1'b0;
            bus.at_floor   <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_code <= FC_NONE;
        end else begin
            bus.at_floor <= 1'b0;
            if (code_next != FC_NONE) begin
                state          <= ST_FAULT;
                bus.fault      <= 1'b1;
                bus.fault_code <= code_next;
                bus.moving     <= 1'b0;
                bus.door_open  <= 1'b0;
            end else begin
                case (state)
                    ST_STOPPED: begin
                        if (bus.motor_up) begin
                            state      <= ST_UP;
                            bus.moving <= 1'b1;
                        end else if (bus.motor_down) begin
                            state      <= ST_DOWN;
                            bus.moving <= 1'b1;
                        end else if (bus.door) begin
                            state         <= ST_DOOR;
                            bus.door_open <= 1'b1;
                        end
                    end
                    ST_UP, ST_DOWN: begin
                        // Landing is registered one tick early so the pulse lands on the last tick.
                        if (count == ARRIVE_AT) begin
                            bus.position <= (state == ST_UP) ? bus.position + POS_W'(1)
                                                             : bus.position - POS_W'(1);
                            bus.at_floor <= 1'b1;
                        end
                        if (terminal && !((state == ST_UP) ? bus.motor_up : bus.motor_down)) begin
                            state      <= ST_STOPPED;
                            bus.moving <= 1'b0;
                        end
                    end
                    ST_DOOR: begin
                        if (terminal) begin
                            state         <= ST_STOPPED;
                            bus.door_open <= 1'b0;
                        end
                    end
                    default: state <= ST_FAULT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_shaft_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_shaft_model
// Purpose  : Self-checking bench; arrivals scoreboarded against floor and cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_shaft_model;
    import elevator_pkg::*;

    localparam int FLOORS = 10;
    localparam int TPF    = 8;
    localparam int DT     = 4;
    localparam int START  = 0;

    typedef struct {
        int floor;
        int cycle;
    } arrival_t;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   c0;
    arrival_t sb[$];

    elevator_shaft_model_if bus();

    elevator_shaft_model #(
        .FLOOR_COUNT     (FLOORS),
        .TICKS_PER_FLOOR (TPF),
        .DOOR_TICKS      (DT),
        .START_FLOOR     (START)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : arrival_mon
        arrival_t a;
        if (bus.at_floor === 1'b1) begin
            check_val("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                a = sb.pop_front();
                check_val("arrival_floor", bus.position, a.floor);
                check_val("arrival_cycle", cyc, a.cycle);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_in(input logic up, input logic down, input logic dr);
        bus.motor_up   = up;
        bus.motor_down = down;
        bus.door       = dr;
    endtask

    task automatic push_travel(input int from, input int dir, input int n, input int start_cyc);
        for (int k = 1; k <= n; k++)
            sb.push_back(arrival_t'{floor: from + dir * k, cycle: start_cyc + TPF * k});
    endtask

    task automatic check_outs(input string tag, input int pos, input logic mv, input logic dop,
                              input logic flt, input int code);
        check_val({tag, ".pos"},   bus.position,   pos);
        check_val({tag, ".move"},  bus.moving,     mv);
        check_val({tag, ".door"},  bus.door_open,  dop);
        check_val({tag, ".fault"}, bus.fault,      flt);
        check_val({tag, ".code"},  bus.fault_code, code);
    endtask

    // Reset is checked while still asserted, before any clock edge, to prove it is asynchronous.
    task automatic do_reset(input string tag);
        set_in(1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #2;
        check_outs(tag, START, 1'b0, 1'b0, 1'b0, 0);
        check_val({tag, ".atf"}, bus.at_floor, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        reset_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        #1;
        do_reset("rst0");

        // Three floors up, then drop the motor during the third arrival pulse.
        c0 = cyc;
        set_in(1'b1, 1'b0, 1'b0);
        push_travel(START, 1, 3, c0);
        step(1);
        check_outs("up_start", START, 1'b1, 1'b0, 1'b0, 0);
        step(3 * TPF - 1);
        set_in(1'b0, 1'b0, 1'b0);
        step(1);
        check_outs("up_stop", 3, 1'b0, 1'b0, 1'b0, 0);

        // Single-cycle motor_down pulse still completes one full traversal.
        c0 = cyc;
        set_in(1'b0, 1'b1, 1'b0);
        push_travel(3, -1, 1, c0);
        step(1);
        set_in(1'b0, 1'b0, 1'b0);
        step(TPF);
        check_outs("down_stop", 2, 1'b0, 1'b0, 1'b0, 0);

        // Door window, then a motor request while the door is open.
        set_in(1'b0, 1'b0, 1'b1);
        step(1);
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= DT + 1; i++) begin
            check_val($sformatf("door_win%0d", i), bus.door_open, (i <= DT) ? 1'b1 : 1'b0);
            step(1);
        end
        set_in(1'b0, 1'b0, 1'b1);
        step(1);
        set_in(1'b0, 1'b0, 1'b0);
        step(1);
        set_in(1'b1, 1'b0, 1'b0);
        step(1);
        check_outs("door_motor", 2, 1'b0, 1'b0, 1'b1, FC_DOOR);

        // Run to the top floor and keep pushing upward.
        do_reset("rst1");
        c0 = cyc;
        set_in(1'b1, 1'b0, 1'b0);
        push_travel(START, 1, FLOORS - 1, c0);
        step((FLOORS - 1) * TPF + 1);
        check_outs("top_over", FLOORS - 1, 1'b0, 1'b0, 1'b1, FC_OVERTRAVEL);
        set_in(1'b0, 1'b0, 1'b0);
        step(3);
        check_outs("fault_hold", FLOORS - 1, 1'b0, 1'b0, 1'b1, FC_OVERTRAVEL);

        do_reset("rst2");
        set_in(1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("bot_over", 0, 1'b0, 1'b0, 1'b1, FC_OVERTRAVEL);

        do_reset("rst3");
        set_in(1'b1, 1'b1, 1'b0);
        step(1);
        check_outs("both", 0, 1'b0, 1'b0, 1'b1, FC_BOTH);

        do_reset("rst4");
        set_in(1'b1, 1'b0, 1'b0);
        step(2);
        set_in(1'b0, 1'b1, 1'b0);
        step(1);
        check_outs("reversal", 0, 1'b0, 1'b0, 1'b1, FC_REVERSAL);

        do_reset("rst5");
        set_in(1'b1, 1'b0, 1'b0);
        step(1);
        set_in(1'b1, 1'b0, 1'b1);
        step(1);
        check_outs("door_move", 0, 1'b0, 1'b0, 1'b1, FC_DOOR);

        // Reset mid-traversal above floor 5, then resume normal travel.
        do_reset("rst6");
        c0 = cyc;
        set_in(1'b1, 1'b0, 1'b0);
        push_travel(START, 1, 5, c0);
        step(5 * TPF + 3);
        check_val("mid.move", bus.moving, 1'b1);
        reset_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        #2;
        check_outs("mid_rst", START, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(1);
        c0 = cyc;
        set_in(1'b1, 1'b0, 1'b0);
        push_travel(START, 1, 1, c0);
        step(1);
        set_in(1'b0, 1'b0, 1'b0);
        step(TPF);
        check_outs("resume", START + 1, 1'b0, 1'b0, 1'b0, 0);

        step(3);
        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
